// File: rtl/ex_issue_ctrl_if.sv
// Bundle of ID, EX and WB signals around the issue controller.
// Handshake: ID offers v_i and holds every ID input while stall_o=1; an
// instruction transfers when v_i & ~stall_o. EX takes v_o when ~stall_i,
// and all EX outputs hold stable while v_o & stall_i.
interface ex_issue_ctrl_if #(
   parameter int W_RD  = 5,
   parameter int W_PAY = 48
);
   logic             v_i;
   logic             stall_o;
   logic             rs_use_i;
   logic             rt_use_i;
   logic [W_RD-1:0]  rs_num_i;
   logic [W_RD-1:0]  rt_num_i;
   logic             wb_i;
   logic [W_RD-1:0]  rd_num_i;
   logic [W_PAY-1:0] pay_i;
   logic             stall_i;
   logic             v_o;
   logic             wb_o;
   logic [W_RD-1:0]  rd_num_o;
   logic [W_PAY-1:0] pay_o;
   logic             ret_i;
   logic [W_RD-1:0]  ret_num_i;
   logic             hazard_o;
   logic [1:0]       infl_o;

   modport master (
      output v_i, rs_use_i, rt_use_i, rs_num_i, rt_num_i, wb_i, rd_num_i, pay_i,
      output stall_i, ret_i, ret_num_i,
      input  stall_o, v_o, wb_o, rd_num_o, pay_o, hazard_o, infl_o
   );

   modport slave (
      input  v_i, rs_use_i, rt_use_i, rs_num_i, rt_num_i, wb_i, rd_num_i, pay_i,
      input  stall_i, ret_i, ret_num_i,
      output stall_o, v_o, wb_o, rd_num_o, pay_o, hazard_o, infl_o
   );
endinterface

// File: rtl/ex_issue_ctrl.sv
// One-entry issue register between ID and EX with a per-register writeback
// scoreboard that stalls ID on RAW/WAW hazards or when the in-flight limit is hit.
module ex_issue_ctrl #(
   parameter int W_RD     = 5,
   parameter int W_PAY    = 48,
   parameter int MAX_INFL = 3,
   parameter int R0_ZERO  = 1
) (
   input logic            clk,
   input logic            rst,
   ex_issue_ctrl_if.slave bus
);
   localparam int         NREG  = 1 << W_RD;
   localparam logic [1:0] MAX_C = 2'(MAX_INFL);

   logic [1:0]       cnt [NREG];
   logic [1:0]       infl;
   logic             v_q;
   logic             wb_q;
   logic [W_RD-1:0]  rd_q;
   logic [W_PAY-1:0] pay_q;

   logic rs_busy, rt_busy, rd_full, infl_full;
   logic hazard, stall, issue, en, inc, dec;

   // Hazards look at the counters as they stand; a same-cycle retire never bypasses.
   always_comb begin
      rs_busy   = (cnt[bus.rs_num_i] != 2'd0) &&
                  !((R0_ZERO != 0) && (bus.rs_num_i == '0));
      rt_busy   = (cnt[bus.rt_num_i] != 2'd0) &&
                  !((R0_ZERO != 0) && (bus.rt_num_i == '0));
      rd_full   = (cnt[bus.rd_num_i] == MAX_C);
      infl_full = (infl == MAX_C);
      hazard    = bus.v_i & ((bus.rs_use_i & rs_busy) | (bus.rt_use_i & rt_busy) |
                             (bus.wb_i & rd_full) | (bus.wb_i & infl_full));
      stall     = hazard | (v_q & bus.stall_i);
      issue     = bus.v_i & ~stall;
      en        = ~v_q | ~bus.stall_i;
      inc       = issue & bus.wb_i & ~((R0_ZERO != 0) && (bus.rd_num_i == '0));
      dec       = bus.ret_i & (cnt[bus.ret_num_i] != 2'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= 1'b0;
         wb_q  <= 1'b0;
         rd_q  <= '0;
         pay_q <= '0;
      end else if (en) begin
         v_q <= issue;
         if (issue) begin
            wb_q  <= bus.wb_i;
            rd_q  <= bus.rd_num_i;
            pay_q <= bus.pay_i;
         end
      end
   end

   // An increment and a decrement landing on the same register cancel out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
         infl <= 2'd0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            case ({inc && (bus.rd_num_i == W_RD'(r)), dec && (bus.ret_num_i == W_RD'(r))})
               2'b10:   cnt[r] <= cnt[r] + 2'd1;
               2'b01:   cnt[r] <= cnt[r] - 2'd1;
               default: cnt[r] <= cnt[r];
            endcase
         end
         case ({inc, dec})
            2'b10:   infl <= infl + 2'd1;
            2'b01:   infl <= infl - 2'd1;
            default: infl <= infl;
         endcase
      end
   end

   assign bus.v_o      = v_q;
   assign bus.wb_o     = wb_q;
   assign bus.rd_num_o = rd_q;
   assign bus.pay_o    = pay_q;
   assign bus.stall_o  = stall;
   assign bus.hazard_o = hazard;
   assign bus.infl_o   = infl;
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl: hazards, in-flight limit, r0, EX backpressure, async reset.
module tb_ex_issue_ctrl;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;
   logic [47:0] exp_q[$];

   ex_issue_ctrl_if #(.W_RD(5), .W_PAY(48)) bus ();

   ex_issue_ctrl #(.W_RD(5), .W_PAY(48), .MAX_INFL(3), .R0_ZERO(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic id(input logic v, input logic rs_use, input logic [4:0] rs,
                     input logic rt_use, input logic [4:0] rt,
                     input logic wb, input logic [4:0] rd, input logic [47:0] pay);
      bus.v_i      = v;
      bus.rs_use_i = rs_use;
      bus.rs_num_i = rs;
      bus.rt_use_i = rt_use;
      bus.rt_num_i = rt;
      bus.wb_i     = wb;
      bus.rd_num_i = rd;
      bus.pay_i    = pay;
   endtask

   task automatic idle();
      id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 48'd0);
   endtask

   task automatic ret(input logic r, input logic [4:0] num);
      bus.ret_i     = r;
      bus.ret_num_i = num;
   endtask

   // EX side scoreboard: every accepted instruction must match the next expected payload.
   always @(negedge clk) begin
      if (rst && bus.v_o && !bus.stall_i) begin
         if (exp_q.size() == 0) chk("ex_unexpected", 64'd1, 64'd0);
         else chk("ex_pay", 64'(bus.pay_o), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b0;
      bus.stall_i = 1'b0;
      idle();
      ret(1'b0, 5'd0);
      tick();
      tick();
      chk("rst_v_o", 64'(bus.v_o), 64'd0);
      chk("rst_infl", 64'(bus.infl_o), 64'd0);
      chk("rst_stall", 64'(bus.stall_o), 64'd0);
      rst = 1'b1;
      tick();

      // independent stream rd=1,2,3 then rd=4 blocked by the in-flight limit
      id(1, 0, 0, 0, 0, 1, 5'd1, 48'h101); exp_q.push_back(48'h101); settle();
      chk("s_haz0", 64'(bus.hazard_o), 64'd0);
      tick();
      id(1, 0, 0, 0, 0, 1, 5'd2, 48'h102); exp_q.push_back(48'h102); settle();
      chk("s_v1", 64'(bus.v_o), 64'd1);
      chk("s_rd1", 64'(bus.rd_num_o), 64'd1);
      chk("s_infl1", 64'(bus.infl_o), 64'd1);
      tick();
      id(1, 0, 0, 0, 0, 1, 5'd3, 48'h103); exp_q.push_back(48'h103); settle();
      chk("s_infl2", 64'(bus.infl_o), 64'd2);
      chk("s_rd2", 64'(bus.rd_num_o), 64'd2);
      tick();
      id(1, 0, 0, 0, 0, 1, 5'd4, 48'h104); exp_q.push_back(48'h104); settle();
      chk("s_infl3", 64'(bus.infl_o), 64'd3);
      chk("s_rd3", 64'(bus.rd_num_o), 64'd3);
      chk("s_wb3", 64'(bus.wb_o), 64'd1);
      chk("s_haz_lim", 64'(bus.hazard_o), 64'd1);
      chk("s_stall_lim", 64'(bus.stall_o), 64'd1);
      tick();
      ret(1, 5'd1); settle();
      chk("s_bubble", 64'(bus.v_o), 64'd0);
      chk("s_haz_ret_same", 64'(bus.hazard_o), 64'd1);
      tick();
      ret(0, 5'd0); settle();
      chk("s_haz_clear", 64'(bus.hazard_o), 64'd0);
      chk("s_infl_after_ret", 64'(bus.infl_o), 64'd2);
      tick();
      idle(); settle();
      chk("s_v4", 64'(bus.v_o), 64'd1);
      chk("s_rd4", 64'(bus.rd_num_o), 64'd4);
      chk("s_infl3b", 64'(bus.infl_o), 64'd3);
      ret(1, 5'd2); tick();
      ret(1, 5'd3); tick();
      ret(1, 5'd4); tick();
      ret(0, 5'd0); settle();
      chk("s_drain", 64'(bus.infl_o), 64'd0);

      // RAW on r5
      id(1, 0, 0, 0, 0, 1, 5'd5, 48'h205); exp_q.push_back(48'h205);
      tick();
      id(1, 1, 5'd5, 0, 0, 0, 5'd0, 48'h206); exp_q.push_back(48'h206); settle();
      chk("raw_stall", 64'(bus.stall_o), 64'd1);
      chk("raw_haz", 64'(bus.hazard_o), 64'd1);
      tick();
      ret(1, 5'd5); settle();
      chk("raw_bubble", 64'(bus.v_o), 64'd0);
      chk("raw_no_bypass", 64'(bus.stall_o), 64'd1);
      tick();
      ret(0, 5'd0); settle();
      chk("raw_issue", 64'(bus.stall_o), 64'd0);
      chk("raw_v_not_yet", 64'(bus.v_o), 64'd0);
      tick();
      idle(); settle();
      chk("raw_v", 64'(bus.v_o), 64'd1);
      chk("raw_wb", 64'(bus.wb_o), 64'd0);
      chk("raw_infl", 64'(bus.infl_o), 64'd0);
      tick();

      // r0 is never busy
      id(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 48'h300); exp_q.push_back(48'h300); settle();
      chk("r0_stall", 64'(bus.stall_o), 64'd0);
      tick();
      id(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 48'h301); exp_q.push_back(48'h301); settle();
      chk("r0_stall2", 64'(bus.stall_o), 64'd0);
      chk("r0_infl", 64'(bus.infl_o), 64'd0);
      tick();
      idle(); settle();
      chk("r0_infl2", 64'(bus.infl_o), 64'd0);
      tick();

      // EX backpressure
      id(1, 0, 0, 0, 0, 0, 5'd8, 48'h408); exp_q.push_back(48'h408);
      tick();
      bus.stall_i = 1'b1;
      id(1, 0, 0, 0, 0, 0, 5'd9, 48'h409); exp_q.push_back(48'h409);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_pay", 64'(bus.pay_o), 64'h408);
         chk("bp_rd", 64'(bus.rd_num_o), 64'd8);
         chk("bp_stall", 64'(bus.stall_o), 64'd1);
         tick();
      end
      bus.stall_i = 1'b0; settle();
      chk("bp_release", 64'(bus.stall_o), 64'd0);
      tick();
      idle(); settle();
      chk("bp_next_pay", 64'(bus.pay_o), 64'h409);
      chk("bp_next_v", 64'(bus.v_o), 64'd1);
      tick();

      // issue and retire of r7 in the same cycle, then a spurious retire of r9
      id(1, 0, 0, 0, 0, 1, 5'd7, 48'h507); exp_q.push_back(48'h507);
      tick();
      id(1, 0, 0, 0, 0, 1, 5'd7, 48'h508); exp_q.push_back(48'h508);
      ret(1, 5'd7); settle();
      chk("sim_stall", 64'(bus.stall_o), 64'd0);
      tick();
      idle(); ret(1, 5'd9); settle();
      chk("sim_infl", 64'(bus.infl_o), 64'd1);
      tick();
      ret(0, 5'd0); settle();
      chk("spur_infl", 64'(bus.infl_o), 64'd1);
      id(1, 1, 5'd7, 0, 0, 0, 5'd0, 48'h509); exp_q.push_back(48'h509); settle();
      chk("sim_cnt7_busy", 64'(bus.hazard_o), 64'd1);
      ret(1, 5'd7);
      tick();
      ret(0, 5'd0); settle();
      chk("sim_cnt7_free", 64'(bus.hazard_o), 64'd0);
      chk("sim_infl0", 64'(bus.infl_o), 64'd0);
      tick();
      idle();
      tick();

      // asynchronous reset in the middle of a stall
      id(1, 0, 0, 0, 0, 1, 5'd10, 48'h60a); exp_q.push_back(48'h60a);
      tick();
      id(1, 0, 0, 0, 0, 1, 5'd11, 48'h60b); exp_q.push_back(48'h60b);
      tick();
      id(1, 1, 5'd10, 0, 0, 0, 5'd0, 48'h60c);
      tick();
      settle();
      chk("ar_infl2", 64'(bus.infl_o), 64'd2);
      chk("ar_stall", 64'(bus.stall_o), 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("ar_v", 64'(bus.v_o), 64'd0);
      chk("ar_wb", 64'(bus.wb_o), 64'd0);
      chk("ar_rd", 64'(bus.rd_num_o), 64'd0);
      chk("ar_pay", 64'(bus.pay_o), 64'd0);
      chk("ar_infl", 64'(bus.infl_o), 64'd0);
      tick();
      rst = 1'b1;
      ret(1, 5'd10); exp_q.push_back(48'h60c); settle();
      chk("ar_no_haz", 64'(bus.hazard_o), 64'd0);
      tick();
      idle(); ret(0, 5'd0); settle();
      chk("ar_issue_v", 64'(bus.v_o), 64'd1);
      chk("ar_issue_pay", 64'(bus.pay_o), 64'h60c);
      chk("ar_spur_infl", 64'(bus.infl_o), 64'd0);
      tick();
      tick();

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
- Issue scheduler between decode (ID) and the execute stage.
- Holds each decoded instruction in a one-entry issue register. Keeps a per-register scoreboard of outstanding writebacks, and stalls ID on RAW/WAW hazards or when the in-flight limit is reached.
- Releases scoreboard entries on writeback retire reports from WB.
- The execute stage consumes the issue register outputs unchanged.

Parameters:
- W_RD, 5, register-number width; NREG = 2**W_RD.
- W_PAY, 48, width of the opaque payload (dopc/opc/src/dest/origaddr bundle) passed through to EX.
- MAX_INFL, 3, maximum outstanding writebacks in total and per register; range 1..3.
- R0_ZERO, 1, when 1, register 0 is never marked busy and never causes a hazard.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- v_i  in  1  ID instruction valid
- stall_o  out  1  stall to ID
- rs_use_i, rt_use_i  in  1 each  source operand read enables
- rs_num_i, rt_num_i  in  W_RD each  source register numbers
- wb_i  in  1  instruction writes rd
- rd_num_i  in  W_RD  destination register
- pay_i  in  W_PAY  payload
- stall_i  in  1  stall from EX
- v_o  out  1  issued instruction valid to EX
- wb_o  out  1  registered wb_i
- rd_num_o  out  W_RD  registered rd_num_i
- pay_o  out  W_PAY  registered pay_i
- ret_i  in  1  WB retires a writeback this cycle
- ret_num_i  in  W_RD  retired register number
- hazard_o  out  1  combinational: stall caused by scoreboard or limit
- infl_o  out  2  total outstanding writebacks

Behaviour:
- Reset (rst low, asynchronous): v_o=0, wb_o=0, rd_num_o=0, pay_o=0, all per-register counters 0, infl_o=0. A reset mid-operation discards in-flight state; retires arriving after reset release are ignored if the counter is already 0.
- Scoreboard: one 2-bit counter cnt[r] per register. busy(r) = cnt[r]!=0, except busy(0)=0 when R0_ZERO=1.
- Hazard (combinational, evaluated against current counters before this cycle's retire):
  - hazard_o = v_i & ( (rs_use_i & busy(rs)) | (rt_use_i & busy(rt)) | (wb_i & cnt[rd]==MAX_INFL) | (wb_i & infl==MAX_INFL) ).
  - A same-cycle retire does not clear a hazard; the instruction issues the following cycle at the earliest. There is no bypass.
- Output register load enable: en = ~v_o | ~stall_i.
- stall_o = hazard_o | (v_o & stall_i).
- Issue event: issue = v_i & ~stall_o.
- On en, the output register loads:
  - v_o <= issue;
  - wb_o, rd_num_o, pay_o <= inputs when issue, otherwise held;
  - so a bubble is inserted when hazard_o=1.
- While v_o & stall_i: all outputs held stable. ID must hold its inputs while stall_o=1.
- Latency: 1 cycle from issue to v_o when no hazard and no stall.
- Scoreboard update, every cycle:
  - inc = issue & wb_i & ~(R0_ZERO & rd==0).
  - dec = ret_i & cnt[ret_num]!=0.
  - inc and dec on the same register: counter unchanged.
  - infl changes by inc-dec.
  - A retire for a register with cnt=0 is ignored and sets no error state.
- Writeback ordering is in-order; the scoreboard counts only and does not track tags.

Test Plan:
- Reset then independent stream: rd=1,2,3 back-to-back, no sources used, stall_i=0 -> v_o high cycles 1..3; infl_o reaches 3; the 4th wb instruction (rd=4) stalls with hazard_o=1 until ret_i, then issues the next cycle.
- RAW: issue rd=5, then rs_use=1/rs=5 -> stall_o=1, v_o=0 bubble. ret_i with ret_num=5 at cycle t -> instruction issues at t+1 and v_o=1 at t+2.
- R0: wb to r0 and read of r0 with R0_ZERO=1 -> no stall, infl_o unchanged.
- EX backpressure: v_o=1 with stall_i=1 for 3 cycles -> rd_num_o/pay_o constant and stall_o=1; when stall_i drops, the next instruction loads in the same cycle.
- Simultaneous issue(rd=7) and ret_i(7) with cnt[7]=1 -> cnt[7] stays 1, infl_o unchanged. A spurious ret_i(9) with cnt=0 -> no change.
- Assert rst low mid-stall with infl_o=2 -> all outputs 0 immediately (asynchronous). After release, an instruction reading the previous rd issues without a hazard.
